hot_pfn_filter_fifo: RTL

- Sits directly upstream of the hot-address pusher, between the hot page tracker and the pusher's page_mig_addr_en/page_mig_addr/page_mig_addr_ready interface.
- Takes raw hot PFNs from the tracker, which has no backpressure. Drops invalid, out-of-range and recently-seen duplicate PFNs, and buffers survivors in a FIFO.
- The pusher drains the FIFO with a valid/ready handshake, so no address is lost while the pusher is busy writing to the HAPB.

---
 rtl/hot_pfn_filter_fifo_pkg.sv | 24 ++
 rtl/hot_pfn_filter_fifo_sync_fifo.sv | 59 +++++
 rtl/hot_pfn_filter_fifo.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hot_pfn_filter_fifo_pkg.sv
// Shared types and constants for the hot PFN filter path.
package hot_pfn_pkg;

  localparam int PFN_W = 33;

  typedef logic [PFN_W-1:0] pfn_t;

  // All-ones PFN is the tracker's "no page" marker.
  localparam pfn_t INVALID_PFN = '1;

  typedef enum logic [2:0] {
    DROP_NONE,
    DROP_INV,
    DROP_RANGE,
    DROP_DUP,
    DROP_FULL
  } drop_cause_e;

  // Drop counters stick at all-ones rather than wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hot_pfn_filter_fifo_sync_fifo.sv
// First-word-fall-through sync FIFO with flush; head reads 0 while empty.
module pfn_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 64
) (
  input  logic                       gclk,
  input  logic                       grst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign level   = cnt;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Data storage; no reset needed since empty masks the head.
  always_ff @(posedge gclk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hot_pfn_filter_fifo.sv
// Filters tracker PFNs (invalid / range / recent duplicate / overflow)
// and buffers survivors for the hot-address pusher.
module hot_pfn_filter_fifo
  import hot_pfn_pkg::*;
#(
  parameter int ADDR_SIZE    = 33,
  parameter int FIFO_DEPTH   = 64,
  parameter int HIST_ENTRIES = 16
) (
  input  logic                          axi4_mm_clk,
  input  logic                          axi4_mm_rst_n,
  input  logic                          flush,
  input  logic                          trk_addr_en,
  input  logic [ADDR_SIZE-1:0]          trk_addr,
  input  logic [32:0]                   csr_addr_lb,
  input  logic [32:0]                   csr_addr_ub,
  output logic                          page_mig_addr_en,
  output logic [ADDR_SIZE-1:0]          page_mig_addr,
  input  logic                          page_mig_addr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   drop_inv_cnt,
  output logic [31:0]                   drop_range_cnt,
  output logic [31:0]                   drop_dup_cnt,
  output logic [31:0]                   drop_full_cnt
);

  localparam int HP_W = $clog2(HIST_ENTRIES);

  logic                                  s1_vld;
  logic [ADDR_SIZE-1:0]                  s1_pfn;
  logic [HIST_ENTRIES-1:0]               hist_vld;
  logic [HIST_ENTRIES-1:0][ADDR_SIZE-1:0] hist_pfn;
  logic [HP_W-1:0]                       hist_ptr;
  logic [HIST_ENTRIES-1:0]               hit;
  drop_cause_e                           cause;
  logic                                  fifo_full, fifo_empty;
  logic                                  push, pop;
  logic                                  is_inv, is_range;

  // S1: register the tracker strobe; flush kills the in-flight PFN.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      s1_vld <= 1'b0;
      s1_pfn <= '0;
    end else begin
      s1_vld <= trk_addr_en && !flush;
      s1_pfn <= trk_addr;
    end
  end

  for (genvar g = 0; g < HIST_ENTRIES; g++) begin : g_hit
    assign hit[g] = hist_vld[g] && (hist_pfn[g] == s1_pfn);
  end

  assign is_inv   = (s1_pfn == ADDR_SIZE'(INVALID_PFN));
  assign is_range = (csr_addr_ub != '0) &&
                    ((pfn_t'(s1_pfn) < csr_addr_lb) || (pfn_t'(s1_pfn) > csr_addr_ub));
  assign pop      = page_mig_addr_en && page_mig_addr_ready;

  // S2: classify the registered PFN, first matching cause wins.
  always_comb begin
    cause = DROP_NONE;
    if (s1_vld) begin
      if (is_inv)                 cause = DROP_INV;
      else if (is_range)          cause = DROP_RANGE;
      else if (|hit)              cause = DROP_DUP;
      else if (fifo_full && !pop) cause = DROP_FULL;
    end
  end

  assign push = s1_vld && (cause == DROP_NONE) && !flush;

  // History ring of recently accepted PFNs, oldest overwritten first.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      hist_vld <= '0;
      hist_pfn <= '0;
      hist_ptr <= '0;
    end else if (flush) begin
      hist_vld <= '0;
      hist_ptr <= '0;
    end else if (push) begin
      hist_vld[hist_ptr] <= 1'b1;
      hist_pfn[hist_ptr] <= s1_pfn;
      hist_ptr <= (hist_ptr == HP_W'(HIST_ENTRIES-1)) ? '0 : hist_ptr + 1'b1;
    end
  end

  // Drop counters; a PFN caught by flush is discarded uncounted.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      drop_inv_cnt   <= '0;
      drop_range_cnt <= '0;
      drop_dup_cnt   <= '0;
      drop_full_cnt  <= '0;
    end else if (!flush) begin
      case (cause)
        DROP_INV:   drop_inv_cnt   <= sat_inc(drop_inv_cnt);
        DROP_RANGE: drop_range_cnt <= sat_inc(drop_range_cnt);
        DROP_DUP:   drop_dup_cnt   <= sat_inc(drop_dup_cnt);
        DROP_FULL:  drop_full_cnt  <= sat_inc(drop_full_cnt);
        default: ;
      endcase
    end
  end

  pfn_sync_fifo #(
    .W     (ADDR_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .gclk   (axi4_mm_clk),
    .grst_n (axi4_mm_rst_n),
    .flush  (flush),
    .push   (push),
    .din    (s1_pfn),
    .pop    (page_mig_addr_ready),
    .dout   (page_mig_addr),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign page_mig_addr_en = !fifo_empty;

endmodule
